light_phase_sequencer: RTL

- Downstream consumer of the mode/flag outputs of the intersection main controller; turns those level flags into actual lamp drives for the main and side roads.
- Runs the green→yellow→red phase cycle on a 1 Hz tick, with per-phase countdown, busy-hour extensions, pedestrian shortening, hold requests, pause, online, police and night-flash modes.
- Outputs drive the lamp pins and feed the seven-segment countdown display.

---
 rtl/light_phase_sequencer_pkg.sv | 29 ++
 rtl/light_phase_sequencer_phase_timer.sv | 37 +++
 rtl/light_phase_sequencer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/light_phase_sequencer_pkg.sv
// Shared traffic definitions: state encodings, lamp vector layout and
// default phase durations (also used by the countdown display block).
package light_phase_sequencer_pkg;

    typedef enum logic [2:0] {
        DARK   = 3'd0,
        FLASH  = 3'd1,
        MG     = 3'd2,
        MY     = 3'd3,
        SG     = 3'd4,
        SY     = 3'd5,
        ALLRED = 3'd6
    } state_t;

    // Lamp vector ordering is {r, y, g}
    typedef logic [2:0] lamp_t;
    localparam lamp_t LAMP_OFF = 3'b000;
    localparam lamp_t LAMP_R   = 3'b100;
    localparam lamp_t LAMP_Y   = 3'b010;
    localparam lamp_t LAMP_G   = 3'b001;

    localparam int unsigned DEF_MAIN_GREEN = 30;
    localparam int unsigned DEF_SUB_GREEN  = 20;
    localparam int unsigned DEF_YELLOW     = 3;
    localparam int unsigned DEF_MORE_EXT   = 10;
    localparam int unsigned DEF_MAN_CUT    = 5;
    localparam int unsigned DEF_CNT_W      = 8;

endpackage

// File: rtl/light_phase_sequencer_phase_timer.sv
// Loadable phase down-counter with cut-to (shorten only), tick enable
// and freeze. expire flags the tick that ends the current phase.
module light_phase_sequencer_phase_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             freeze,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             cut,
    input  logic [CNT_W-1:0] cut_val,
    output logic [CNT_W-1:0] count,
    output logic             expire
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    assign expire = tick && (count == ONE);

    // Counter: load beats cut, cut beats a tick decrement, freeze beats all
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (!freeze) begin
            if (load) begin
                count <= load_val;
            end else if (cut && (count > cut_val)) begin
                count <= cut_val;
            end else if (tick && (count > ONE)) begin
                count <= count - ONE;
            end
        end
    end

endmodule

// File: rtl/light_phase_sequencer.sv
// Lamp phase sequencer: turns controller mode flags into main/side lamp
// drives, running the green/yellow/red cycle on the 1 Hz tick.
module light_phase_sequencer
    import light_phase_sequencer_pkg::*;
#(
    parameter int unsigned MAIN_GREEN = DEF_MAIN_GREEN,
    parameter int unsigned SUB_GREEN  = DEF_SUB_GREEN,
    parameter int unsigned YELLOW     = DEF_YELLOW,
    parameter int unsigned MORE_EXT   = DEF_MORE_EXT,
    parameter int unsigned MAN_CUT    = DEF_MAN_CUT,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             off_r,
    input  logic             polic,
    input  logic             yellow_r,
    input  logic             pause_r,
    input  logic             online_r,
    input  logic             busy_r,
    input  logic             main_more,
    input  logic             sub_more,
    input  logic             main_green_change,
    input  logic             main_red_change,
    input  logic             main_man,
    input  logic             sub_man,
    output logic             main_r,
    output logic             main_y,
    output logic             main_g,
    output logic             sub_r,
    output logic             sub_y,
    output logic             sub_g,
    output logic [CNT_W-1:0] countdown,
    output logic [2:0]       phase
);

    localparam logic [CNT_W-1:0] MAIN_V = CNT_W'(MAIN_GREEN);
    localparam logic [CNT_W-1:0] SUB_V  = CNT_W'(SUB_GREEN);
    localparam logic [CNT_W-1:0] YEL_V  = CNT_W'(YELLOW);
    localparam logic [CNT_W-1:0] EXT_V  = CNT_W'(MORE_EXT);
    localparam logic [CNT_W-1:0] CUT_V  = CNT_W'(MAN_CUT);

    state_t           state, state_nxt;
    logic             held, held_nxt;
    logic             toggle, toggle_nxt;
    lamp_t            main_nxt, sub_nxt;
    logic             load, cut, freeze, expire;
    logic [CNT_W-1:0] load_val, main_len, sub_len;

    assign main_len = MAIN_V + ((busy_r && main_more) ? EXT_V : '0);
    assign sub_len  = SUB_V  + ((busy_r && sub_more)  ? EXT_V : '0);
    assign phase    = state;

    light_phase_sequencer_phase_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .freeze  (freeze),
        .load    (load),
        .load_val(load_val),
        .cut     (cut),
        .cut_val (CUT_V),
        .count   (countdown),
        .expire  (expire)
    );

    // Mode priority, phase advance and lamp decode of the next state.
    // held marks the online hold so the first normal clk reloads the
    // (possibly extended) main green rather than continuing the count.
    always_comb begin
        state_nxt  = state;
        held_nxt   = held;
        toggle_nxt = toggle;
        load       = 1'b0;
        load_val   = '0;
        cut        = 1'b0;
        freeze     = 1'b0;
        if (off_r) begin
            state_nxt = DARK;
            load      = 1'b1;
            held_nxt  = 1'b0;
        end else if (polic) begin
            state_nxt = ALLRED;
            load      = 1'b1;
            held_nxt  = 1'b0;
        end else if (yellow_r) begin
            state_nxt  = FLASH;
            load       = 1'b1;
            held_nxt   = 1'b0;
            toggle_nxt = toggle ^ tick;
        end else if (pause_r) begin
            freeze = 1'b1;
        end else if (online_r) begin
            state_nxt = MG;
            load      = 1'b1;
            load_val  = MAIN_V;
            held_nxt  = 1'b1;
        end else if (held) begin
            state_nxt = MG;
            load      = 1'b1;
            load_val  = main_len;
            held_nxt  = 1'b0;
        end else begin
            case (state)
                DARK, FLASH, ALLRED: begin
                    state_nxt = MG;
                    load      = 1'b1;
                    load_val  = main_len;
                end
                MG: begin
                    cut = main_man;
                    if (expire) begin
                        load = 1'b1;
                        if (main_green_change) begin
                            load_val = main_len;
                        end else begin
                            state_nxt = MY;
                            load_val  = YEL_V;
                        end
                    end
                end
                MY: begin
                    if (expire) begin
                        state_nxt = SG;
                        load      = 1'b1;
                        load_val  = sub_len;
                    end
                end
                SG: begin
                    cut = sub_man;
                    if (expire) begin
                        load = 1'b1;
                        if (main_red_change) begin
                            load_val = sub_len;
                        end else begin
                            state_nxt = SY;
                            load_val  = YEL_V;
                        end
                    end
                end
                SY: begin
                    if (expire) begin
                        state_nxt = MG;
                        load      = 1'b1;
                        load_val  = main_len;
                    end
                end
                default: begin
                    state_nxt = DARK;
                    load      = 1'b1;
                end
            endcase
        end

        main_nxt = LAMP_OFF;
        sub_nxt  = LAMP_OFF;
        case (state_nxt)
            FLASH: begin
                main_nxt = {1'b0, toggle_nxt, 1'b0};
                sub_nxt  = {1'b0, toggle_nxt, 1'b0};
            end
            MG:      begin main_nxt = LAMP_G; sub_nxt = LAMP_R; end
            MY:      begin main_nxt = LAMP_Y; sub_nxt = LAMP_R; end
            SG:      begin main_nxt = LAMP_R; sub_nxt = LAMP_G; end
            SY:      begin main_nxt = LAMP_R; sub_nxt = LAMP_Y; end
            ALLRED:  begin main_nxt = LAMP_R; sub_nxt = LAMP_R; end
            default: begin main_nxt = LAMP_OFF; sub_nxt = LAMP_OFF; end
        endcase
    end

    // State, hold flag, flash toggle and registered lamp drives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                   <= DARK;
            held                    <= 1'b0;
            toggle                  <= 1'b0;
            {main_r, main_y, main_g} <= LAMP_OFF;
            {sub_r, sub_y, sub_g}    <= LAMP_OFF;
        end else begin
            state                   <= state_nxt;
            held                    <= held_nxt;
            toggle                  <= toggle_nxt;
            {main_r, main_y, main_g} <= main_nxt;
            {sub_r, sub_y, sub_g}    <= sub_nxt;
        end
    end

endmodule
